// File: rtl/regbank_write_arbiter_pkg.sv
// Shared register-bank constants and helpers for the write arbiter.
package regbank_write_arbiter_pkg;

  localparam int REG_AW = 5;
  localparam int REG_DW = 32;
  localparam int GID_W = 3;
  localparam logic [REG_AW-1:0] ZERO_ADDR = '0;
  localparam logic [15:0] COUNT_MAX = 16'hFFFF;

  // Round-robin successor of a requester index, wrapping at nreq.
  function automatic logic [GID_W-1:0] next_ptr(input logic [GID_W-1:0] id, input int nreq);
    return (int'(id) == nreq - 1) ? '0 : id + GID_W'(1);
  endfunction

endpackage

// File: rtl/regbank_write_arbiter_rr_select.sv
// Round-robin picker: first valid requester at or above ptr, wrapping modulo NREQ.
module regbank_write_arbiter_rr_select
  import regbank_write_arbiter_pkg::*;
#(
  parameter int NREQ = 3
) (
  input  logic [NREQ-1:0]  valid,
  input  logic [GID_W-1:0] ptr,
  output logic [NREQ-1:0]  grant
);

  always_comb begin
    logic found;
    int idx;
    grant = '0;
    found = 1'b0;
    idx = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && valid[idx]) begin
        grant[idx] = 1'b1;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regbank_write_arbiter.sv
// Round-robin arbiter funnelling NREQ write requesters into a single register-bank
// write port, with read-hazard flags and a saturating committed-write counter.
module regbank_write_arbiter
  import regbank_write_arbiter_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int DW = REG_DW,
  parameter int AW = REG_AW
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  input  logic               hlt,
  output logic               wr_en,
  output logic [AW-1:0]      wr_addr,
  output logic [DW-1:0]      wr_data,
  output logic [GID_W-1:0]   grant_id,
  input  logic [AW-1:0]      rd_addr1,
  input  logic [AW-1:0]      rd_addr2,
  output logic               hit1,
  output logic               hit2,
  output logic [15:0]        wr_count,
  output logic [GID_W-1:0]   rr_ptr
);

  // Handshake: requester i transfers in any cycle where req_valid[i] && req_ready[i];
  // ready is combinational, never depends on itself, and the requester must hold
  // valid/addr/data stable until it sees ready.
  logic [NREQ-1:0]  grant;
  logic             xfer;
  logic             wr_next;
  logic [GID_W-1:0] win_id;
  logic [AW-1:0]    win_addr;
  logic [DW-1:0]    win_data;

  regbank_write_arbiter_rr_select #(.NREQ(NREQ)) u_rr_select (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  assign req_ready = hlt ? '0 : grant;
  assign xfer      = |(req_valid & req_ready);
  assign wr_next   = xfer && (win_addr != AW'(ZERO_ADDR));

  always_comb begin
    win_id   = '0;
    win_addr = '0;
    win_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        win_id   = GID_W'(i);
        win_addr = req_addr[i*AW +: AW];
        win_data = req_data[i*DW +: DW];
      end
    end
  end

  assign hit1 = wr_en && (wr_addr == rd_addr1);
  assign hit2 = wr_en && (wr_addr == rd_addr2);

  // wr_count advances on the same edge that raises wr_en, so it always
  // includes the write currently on the output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      grant_id <= '0;
      wr_count <= '0;
      rr_ptr   <= '0;
    end else begin
      wr_en <= wr_next;
      if (xfer) begin
        wr_addr  <= win_addr;
        wr_data  <= win_data;
        grant_id <= win_id;
        rr_ptr   <= next_ptr(win_id, NREQ);
      end
      if (wr_next && (wr_count != COUNT_MAX)) begin
        wr_count <= wr_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// Bench for regbank_write_arbiter: directed scenarios plus a randomized run,
// all checked against a behavioural model of the arbitration rules.
module tb_regbank_write_arbiter;

  localparam int NREQ = 3;
  localparam int AW = 5;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ*AW-1:0] req_addr = '0;
  logic [NREQ*DW-1:0] req_data = '0;
  logic [NREQ-1:0]   req_ready;
  logic              hlt = 1'b0;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic [2:0]        grant_id;
  logic [AW-1:0]     rd_addr1 = '0;
  logic [AW-1:0]     rd_addr2 = '0;
  logic              hit1;
  logic              hit2;
  logic [15:0]       wr_count;
  logic [2:0]        rr_ptr;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int          m_ptr;
  bit          m_wr_en;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  int          m_gid;
  int          m_count;

  logic [2:0] exp_q[$];

  regbank_write_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .hlt       (hlt),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .grant_id  (grant_id),
    .rd_addr1  (rd_addr1),
    .rd_addr2  (rd_addr2),
    .hit1      (hit1),
    .hit2      (hit2),
    .wr_count  (wr_count),
    .rr_ptr    (rr_ptr)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_wr_en = 0; m_addr = '0; m_data = '0; m_gid = 0; m_count = 0;
  endtask

  function automatic int pick();
    if (hlt) return -1;
    for (int k = 0; k < NREQ; k++) begin
      if (req_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_wr_en"}, 64'(wr_en), 64'd0);
    chk({tag, "_wr_addr"}, 64'(wr_addr), 64'd0);
    chk({tag, "_wr_data"}, 64'(wr_data), 64'd0);
    chk({tag, "_grant_id"}, 64'(grant_id), 64'd0);
    chk({tag, "_wr_count"}, 64'(wr_count), 64'd0);
    chk({tag, "_rr_ptr"}, 64'(rr_ptr), 64'd0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_zero_outputs("reset");
    req_valid = '0;
    hlt = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input bit v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i] = v;
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  // One clock: check combinational outputs, advance model across the edge,
  // then check registered outputs. Entered and left at posedge+1.
  task automatic tick(input bit chk_on, output int w);
    logic [NREQ-1:0] exp_ready;
    logic [AW-1:0] a;
    #1;
    w = pick();
    exp_ready = (w >= 0) ? NREQ'(1 << w) : '0;
    if (chk_on) begin
      chk("req_ready", 64'(req_ready), 64'(exp_ready));
      chk("hit1", 64'(hit1), 64'(m_wr_en && (m_addr == rd_addr1)));
      chk("hit2", 64'(hit2), 64'(m_wr_en && (m_addr == rd_addr2)));
    end
    @(posedge clk);
    if (w >= 0) begin
      a = req_addr[w*AW +: AW];
      m_wr_en = (a != 0);
      m_addr = a;
      m_data = req_data[w*DW +: DW];
      m_gid = w;
      m_ptr = (w + 1) % NREQ;
      if (m_wr_en && m_count < 65535) m_count++;
    end else begin
      m_wr_en = 0;
    end
    #1;
    if (chk_on) begin
      chk("wr_en", 64'(wr_en), 64'(m_wr_en));
      chk("wr_addr", 64'(wr_addr), 64'(m_addr));
      chk("wr_data", 64'(wr_data), 64'(m_data));
      chk("grant_id", 64'(grant_id), 64'(m_gid));
      chk("wr_count", 64'(wr_count), 64'(m_count));
      chk("rr_ptr", 64'(rr_ptr), 64'(m_ptr));
    end
  endtask

  initial begin : main
    int w;
    int cnt_before;
    bit timed_out;
    timed_out = 0;

    // Reset state
    apply_reset();

    // Single write from requester 1
    set_req(1, 1'b1, 5'd7, 32'hDEADBEEF);
    tick(1, w);
    chk("d1_wr_en", 64'(wr_en), 64'd1);
    chk("d1_wr_addr", 64'(wr_addr), 64'd7);
    chk("d1_wr_data", 64'(wr_data), 64'hDEADBEEF);
    chk("d1_grant_id", 64'(grant_id), 64'd1);
    chk("d1_wr_count", 64'(wr_count), 64'd1);

    // All requesters valid from reset: strict rotation
    apply_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, AW'(i + 4), DW'($urandom));
    exp_q = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd1, 3'd2};
    for (int c = 0; c < 6; c++) begin
      #1;
      chk("rot_onehot", 64'($onehot(req_ready)), 64'd1);
      #1;
      tick(1, w);
      chk("rot_order", 64'(grant_id), 64'(exp_q.pop_front()));
    end

    // Write to register 0: accepted, pointer advances, no strobe
    req_valid = '0;
    set_req(0, 1'b1, 5'd0, 32'h12345678);
    cnt_before = m_count;
    #1;
    chk("z_ready0", 64'(req_ready), 64'd1);
    #1;
    tick(1, w);
    chk("z_wr_en", 64'(wr_en), 64'd0);
    chk("z_wr_count", 64'(wr_count), 64'(cnt_before));
    chk("z_rr_ptr", 64'(rr_ptr), 64'd1);

    // Halt right after a transfer: pending write still commits
    req_valid = '0;
    set_req(2, 1'b1, 5'd9, 32'hCAFE0009);
    tick(1, w);
    cnt_before = m_count;
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, AW'(i + 20), DW'($urandom));
    hlt = 1'b1;
    #1;
    chk("h_ready", 64'(req_ready), 64'd0);
    chk("h_wr_en_pending", 64'(wr_en), 64'd1);
    chk("h_wr_addr", 64'(wr_addr), 64'd9);
    #1;
    tick(1, w);
    chk("h_wr_en_after", 64'(wr_en), 64'd0);
    chk("h_wr_count", 64'(wr_count), 64'(cnt_before));
    tick(1, w);
    hlt = 1'b0;

    // Hazard flags
    req_valid = '0;
    set_req(0, 1'b1, 5'd12, 32'h0000000C);
    rd_addr1 = 5'd12;
    rd_addr2 = 5'd3;
    tick(1, w);
    req_valid = '0;
    #1;
    chk("hz_hit1", 64'(hit1), 64'd1);
    chk("hz_hit2", 64'(hit2), 64'd0);
    #1;
    tick(1, w);

    // Randomized traffic with requester hold discipline
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] || w == i)
          set_req(i, $urandom_range(0, 2) != 0, AW'($urandom_range(0, 7)), DW'($urandom));
      end
      hlt = ($urandom_range(0, 4) == 0);
      rd_addr1 = AW'($urandom_range(0, 7));
      rd_addr2 = AW'($urandom_range(0, 7));
      tick(1, w);
    end
    hlt = 1'b0;

    // Saturation: 65535 writes fill the counter, one more must not wrap
    apply_reset();
    req_valid = '0;
    set_req(1, 1'b1, 5'd17, 32'h5A5A5A5A);
    for (int c = 0; c < 65535; c++) tick(0, w);
    chk("sat_full", 64'(wr_count), 64'hFFFF);
    tick(1, w);
    chk("sat_hold", 64'(wr_count), 64'hFFFF);
    chk("sat_wr_en", 64'(wr_en), 64'd1);

    // Asynchronous reset mid-stream, then arbitration restarts at requester 0
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, AW'(i + 1), DW'($urandom));
    tick(1, w);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_zero_outputs("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    // Bounded wait for the release to be seen before the next edge
    fork
      begin : wait_ready
        wait (req_ready == 3'b001);
      end
      begin : wait_bound
        #3;
        timed_out = 1;
      end
    join_any
    disable fork;
    chk("post_rst_timeout", 64'(timed_out), 64'd0);
    @(posedge clk);
    #1;
    w = 0;
    m_wr_en = 1; m_addr = 5'd1; m_data = req_data[0 +: DW]; m_gid = 0; m_ptr = 1; m_count = 1;
    chk("post_rst_grant", 64'(grant_id), 64'd0);
    chk("post_rst_wr_addr", 64'(wr_addr), 64'd1);
    chk("post_rst_count", 64'(wr_count), 64'd1);
    tick(1, w);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    errors++;
    $display("FAIL watchdog simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "time limit");
  end

endmodule
